// File: rtl/fb_memory_param.sv
// Parametrised framebuffer store: Wishbone read/write port, pixel read-only port,
// and a fill engine that overwrites every word with one value.
module fb_memory_param #(
  parameter  int DATA_WIDTH   = 32,
  parameter  int DEPTH        = 38400,
  parameter  int READ_LATENCY = 2,
  localparam int BE           = DATA_WIDTH / 8,
  localparam int AW           = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [AW-1:0]         wb_address,
  input  logic                  wb_read_req,
  input  logic [BE-1:0]         wb_write_enable,
  input  logic [DATA_WIDTH-1:0] wb_write_data,
  output logic [DATA_WIDTH-1:0] wb_read_data,
  output logic                  wb_read_valid,
  output logic                  wb_busy,
  input  logic [AW-1:0]         px_address,
  input  logic                  px_read_req,
  output logic [DATA_WIDTH-1:0] px_read_data,
  output logic                  px_read_valid,
  input  logic                  fill_start,
  input  logic [DATA_WIDTH-1:0] fill_value,
  output logic                  fill_done
);

  localparam int              NP        = 2;  // port 0 = Wishbone, port 1 = pixel
  localparam logic [AW:0]     DEPTH_W   = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]   LAST_ADDR = AW'(DEPTH - 1);

  function automatic logic in_range(logic [AW-1:0] a);
    return {1'b0, a} < DEPTH_W;
  endfunction

  typedef enum logic {IDLE, FILL} fill_state_t;

  fill_state_t           state, state_d;
  logic [AW-1:0]         fill_addr, fill_addr_d;
  logic [DATA_WIDTH-1:0] fill_val, fill_val_d;
  logic                  fill_done_d;

  always_comb begin
    state_d     = state;
    fill_addr_d = fill_addr;
    fill_val_d  = fill_val;
    fill_done_d = 1'b0;
    case (state)
      IDLE: if (fill_start) begin
        state_d     = FILL;
        fill_addr_d = '0;
        fill_val_d  = fill_value;
      end
      FILL: begin
        fill_addr_d = fill_addr + 1'b1;
        if (fill_addr == LAST_ADDR) begin
          state_d     = IDLE;
          fill_done_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      fill_addr <= '0;
      fill_val  <= '0;
      fill_done <= 1'b0;
    end else begin
      state     <= state_d;
      fill_addr <= fill_addr_d;
      fill_val  <= fill_val_d;
      fill_done <= fill_done_d;
    end
  end

  assign wb_busy = (state == FILL);

  // Single write port: the fill engine preempts Wishbone; nothing is written in reset.
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [BE-1:0]         wr_be;
  logic [DATA_WIDTH-1:0] wr_data;

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = wb_address;
    wr_be   = wb_write_enable;
    wr_data = wb_write_data;
    if (wb_busy) begin
      wr_en   = !rst;
      wr_addr = fill_addr;
      wr_be   = '1;
      wr_data = fill_val;
    end else begin
      wr_en = !rst && (|wb_write_enable) && in_range(wb_address);
    end
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en)
      for (int b = 0; b < BE; b++)
        if (wr_be[b]) mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
  end

  // Read ports. Stage 1 samples the array before this edge's write lands (read-first);
  // each later stage only advances on a valid so data holds between pulses.
  logic [NP-1:0][AW-1:0]                          rd_addr;
  logic [NP-1:0]                                  rd_req;
  logic [NP-1:0][READ_LATENCY:1]                  vld_pipe;
  logic [NP-1:0][READ_LATENCY:1][DATA_WIDTH-1:0]  dat_pipe;

  assign rd_addr = {px_address, wb_address};
  assign rd_req  = {px_read_req, wb_read_req};

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        vld_pipe[p][1] <= rd_req[p];
        if (rd_req[p]) dat_pipe[p][1] <= in_range(rd_addr[p]) ? mem[rd_addr[p]] : '0;
        for (int k = 2; k <= READ_LATENCY; k++) begin
          vld_pipe[p][k] <= vld_pipe[p][k-1];
          if (vld_pipe[p][k-1]) dat_pipe[p][k] <= dat_pipe[p][k-1];
        end
      end
    end
  end

  assign wb_read_valid = vld_pipe[0][READ_LATENCY];
  assign wb_read_data  = dat_pipe[0][READ_LATENCY];
  assign px_read_valid = vld_pipe[1][READ_LATENCY];
  assign px_read_data  = dat_pipe[1][READ_LATENCY];

endmodule

// File: doc/fb_memory_param.md
Name: fb_memory_param

Overview:
- Parametrised single-clock framebuffer memory: one Wishbone-side read/write port, one pixel-side read-only port.
- Generalises the fixed 38400x32 VGA frame store to configurable word width, depth and read latency.
- Adds explicit read-request/valid tracking, out-of-range protection and a hardware fill (clear-screen) engine.
- Sits between the Wishbone slave adapter and the pixel/scan-out logic.

Parameters:
- DATA_WIDTH, 32, word width in bits; multiple of 8; BE = DATA_WIDTH/8.
- DEPTH, 38400, number of words; AW = $clog2(DEPTH).
- READ_LATENCY, 2, cycles from read request to valid data, legal range 1..3, same for both ports.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- wb_address  in  AW  Wishbone word address.
- wb_read_req  in  1  Wishbone read request.
- wb_write_enable  in  BE  per-byte write enable.
- wb_write_data  in  DATA_WIDTH  write data.
- wb_read_data  out  DATA_WIDTH  Wishbone read data.
- wb_read_valid  out  1  one-cycle pulse marking wb_read_data valid.
- wb_busy  out  1  high while the fill engine owns the write path.
- px_address  in  AW  pixel-port word address.
- px_read_req  in  1  pixel read request.
- px_read_data  out  DATA_WIDTH  pixel read data.
- px_read_valid  out  1  one-cycle pulse marking px_read_data valid.
- fill_start  in  1  start a fill of the whole memory.
- fill_value  in  DATA_WIDTH  fill word, sampled on the accepted fill_start.
- fill_done  out  1  one-cycle pulse on fill completion.

Behaviour:
Reset:
- All outputs are 0.
- Fill FSM goes to IDLE; valid pipelines are cleared.
- Memory contents are not reset.
- Reset mid-fill aborts the fill: words already written keep fill_value, the rest keep old data, and no fill_done is generated.

Reads:
- A request in cycle N produces data and a valid pulse in cycle N+READ_LATENCY, on either port.
- Back-to-back requests give back-to-back valids.
- Read data holds its last value between valids.
- Address >= DEPTH returns all zeros, with valid still pulsed.

Writes:
- Byte lane i is written when wb_write_enable[i]=1.
- Address >= DEPTH: write is ignored.
- Write and read may share a cycle on the Wishbone port.

Collision (read-first):
- A read of the address being written in the same cycle returns the old word, on either port.
- A read issued the cycle after the write returns the new word.

Fill FSM:
- IDLE -> FILL on fill_start: latch fill_value, addr counter = 0, wb_busy=1.
- FILL: write the full latched word to addr every cycle, addr increments; DEPTH cycles total.
- After writing DEPTH-1 -> IDLE, fill_done=1 for exactly one cycle, wb_busy=0 in that same cycle.
- fill_start while in FILL is ignored.
- Wishbone writes while wb_busy=1 are dropped (no queuing).
- Reads on both ports continue during FILL, using read-first semantics against the fill write.

Test Plan:
1. Reset, then write 0xDEADBEEF to addr 5 with WE=1111, then px_read_req addr 5 -> px_read_valid exactly 2 cycles later, data 0xDEADBEEF; both valids and data are 0 during reset.
2. Addr 7 holds 0x11223344; write 0xAABBCCDD with WE=0101 -> wb read returns 0x11BB33DD.
3. Addr 9 holds 0x0; same cycle: write 0x5A5A5A5A to addr 9 and px_read addr 9 -> px gets 0x00000000; px read on the next cycle -> 0x5A5A5A5A.
4. Back-to-back px reads of addrs 0..3 plus a read of addr 38400 -> 5 consecutive valids; last data = 0.
5. fill_start with 0x000000FF; wb write attempted mid-fill; second fill_start mid-fill -> wb_busy high for exactly DEPTH cycles, fill_done a single pulse, every address reads 0x000000FF, dropped write not visible.
6. Assert rst after 100 fill cycles -> addrs 0..99 = fill value, addr 100 unchanged, no fill_done, wb_busy=0 after reset.
7. Repeat tests 1 and 4 with READ_LATENCY=1 and 3, and with DATA_WIDTH=64, DEPTH=1024 -> latency and byte lanes scale accordingly.
